// File: rtl/cfg_chain_sequencer.sv
// Drives the fabric configuration shift chain: serialises LOAD bytes LSB-first,
// reads the chain back non-destructively by recirculation, and zero-fills on CLEAR.
module cfg_chain_sequencer #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic       SYSCLK,
    input  logic       SYSRST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic       WR_VALID,
    output logic       WR_READY,
    input  logic [7:0] WR_DATA,
    output logic       RB_VALID,
    input  logic       RB_READY,
    output logic [7:0] RB_DATA,
    output logic       SHIFT_HEAD,
    output logic       SHIFT_ENABLE,
    input  logic       SHIFT_TAIL,
    input  logic       ABORT,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [2:0] DBG_STATE
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD_WAIT  = 3'd1;
    localparam logic [2:0] S_LOAD_SHIFT = 3'd2;
    localparam logic [2:0] S_RB_SHIFT   = 3'd3;
    localparam logic [2:0] S_RB_SEND    = 3'd4;
    localparam logic [2:0] S_CLR_SHIFT  = 3'd5;
    localparam logic [2:0] S_FINISH     = 3'd6;

    // Every valid/ready pair transfers on a rising edge where both are high;
    // a producer holds valid and data stable until that edge.

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       shifter, shifter_nx;
    logic [7:0]       rb_data, rb_data_nx;
    logic             shift_en, shift_en_nx;
    logic             done_q, err_q;
    logic             last_bit, byte_end, all_sent;

    assign last_bit = (cnt == CNT_W'(CHAIN_LEN - 1));
    assign all_sent = (cnt == CNT_W'(CHAIN_LEN));
    assign byte_end = (cnt[2:0] == 3'd7);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        shifter_nx = shifter;
        rb_data_nx = rb_data;
        case (state)
            S_IDLE: begin
                if (CMD_VALID) begin
                    cnt_nx = '0;
                    case (CMD_OP)
                        2'd1:    state_nx = S_LOAD_WAIT;
                        2'd2:    state_nx = S_RB_SHIFT;
                        2'd3:    state_nx = S_CLR_SHIFT;
                        default: state_nx = S_IDLE;
                    endcase
                end
            end
            S_LOAD_WAIT: begin
                if (WR_VALID) begin
                    shifter_nx = WR_DATA;
                    state_nx   = S_LOAD_SHIFT;
                end
            end
            S_LOAD_SHIFT: begin
                shifter_nx = {1'b0, shifter[7:1]};
                cnt_nx     = cnt + 1'b1;
                if (last_bit)      state_nx = S_FINISH;
                else if (byte_end) state_nx = S_LOAD_WAIT;
            end
            S_RB_SHIFT: begin
                // First bit of each byte clears the upper bits so a short final byte reads 0 above.
                if (cnt[2:0] == 3'd0) rb_data_nx = {7'b0, SHIFT_TAIL};
                else                  rb_data_nx[cnt[2:0]] = SHIFT_TAIL;
                cnt_nx = cnt + 1'b1;
                if (last_bit || byte_end) state_nx = S_RB_SEND;
            end
            S_RB_SEND: begin
                if (RB_READY) state_nx = all_sent ? S_FINISH : S_RB_SHIFT;
            end
            S_CLR_SHIFT: begin
                cnt_nx = cnt + 1'b1;
                if (last_bit) state_nx = S_FINISH;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (ABORT && (state != S_IDLE)) state_nx = S_IDLE;
    end

    // Chain enable is registered from the next state so it is high exactly while in a shift state.
    assign shift_en_nx = (state_nx == S_LOAD_SHIFT) || (state_nx == S_RB_SHIFT) ||
                         (state_nx == S_CLR_SHIFT);

    always_ff @(posedge SYSCLK or negedge SYSRST) begin
        if (!SYSRST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            shifter  <= '0;
            rb_data  <= '0;
            shift_en <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            shifter  <= shifter_nx;
            rb_data  <= rb_data_nx;
            shift_en <= shift_en_nx;
            done_q   <= (state == S_FINISH) && !ABORT;
            err_q    <= ABORT && (state != S_IDLE);
        end
    end

    always_comb begin
        SHIFT_HEAD = 1'b0;
        if (shift_en) begin
            case (state)
                S_LOAD_SHIFT: SHIFT_HEAD = shifter[0];
                S_RB_SHIFT:   SHIFT_HEAD = SHIFT_TAIL;
                default:      SHIFT_HEAD = 1'b0;
            endcase
        end
    end

    assign SHIFT_ENABLE = shift_en;
    assign CMD_READY    = (state == S_IDLE);
    assign WR_READY     = (state == S_LOAD_WAIT);
    assign RB_VALID     = (state == S_RB_SEND);
    assign RB_DATA      = rb_data;
    assign BUSY         = (state != S_IDLE);
    assign DONE         = done_q;
    assign ERROR        = err_q;
    assign DBG_STATE    = state;

endmodule

// File: tb/tb_cfg_chain_sequencer.sv
// Randomised bench for cfg_chain_sequencer with a behavioural chain and a
// bit-list reference model; a negedge monitor checks heads and readback bytes.
module tb_cfg_chain_sequencer;
  localparam int L     = 12;
  localparam int NB    = (L + 7) / 8;
  localparam int CNT_W = 16;

  logic SYSCLK = 1'b0;
  logic SYSRST = 1'b0;
  logic CMD_VALID = 1'b0;
  logic CMD_READY;
  logic [1:0] CMD_OP = 2'd0;
  logic WR_VALID = 1'b0;
  logic WR_READY;
  logic [7:0] WR_DATA = 8'd0;
  logic RB_VALID;
  logic RB_READY = 1'b0;
  logic [7:0] RB_DATA;
  logic SHIFT_HEAD, SHIFT_ENABLE, SHIFT_TAIL;
  logic ABORT = 1'b0;
  logic BUSY, DONE, ERROR;
  logic [2:0] DBG_STATE;

  cfg_chain_sequencer #(.CHAIN_LEN(L), .CNT_W(CNT_W)) dut (
    .SYSCLK(SYSCLK), .SYSRST(SYSRST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
    .RB_VALID(RB_VALID), .RB_READY(RB_READY), .RB_DATA(RB_DATA),
    .SHIFT_HEAD(SHIFT_HEAD), .SHIFT_ENABLE(SHIFT_ENABLE), .SHIFT_TAIL(SHIFT_TAIL),
    .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int ce_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0;

  logic [0:0] exp_head_q[$];
  logic [7:0] exp_rb_q[$];

  // Behavioural chain: front of queue is the tail bit.
  logic chain_q[$];
  logic tail_bit = 1'b0;
  logic ce_s = 1'b0, head_s = 1'b0;
  // Reference model: model_bits[i] is the i-th bit the chain will emit next.
  logic model_bits[L];

  assign SHIFT_TAIL = tail_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge SYSCLK) cyc <= cyc + 1;

  always @(negedge SYSCLK) begin
    ce_s   <= SHIFT_ENABLE;
    head_s <= SHIFT_HEAD;
  end

  always @(posedge SYSCLK) begin
    if (ce_s === 1'b1) begin
      void'(chain_q.pop_front());
      chain_q.push_back(head_s);
      tail_bit <= chain_q[0];
    end
  end

  // scoreboard monitor
  always @(negedge SYSCLK) begin
    if (SYSRST) begin
      if (SHIFT_ENABLE) begin
        ce_cnt <= ce_cnt + 1;
        if (exp_head_q.size() == 0) check("ce_unexpected", 32'(SHIFT_ENABLE), 32'd0);
        else check("shift_head", 32'(SHIFT_HEAD), 32'(exp_head_q.pop_front()));
      end else begin
        check("head_gate", 32'(SHIFT_HEAD), 32'd0);
      end
      if (WR_VALID && WR_READY) wr_cnt <= wr_cnt + 1;
      if (RB_VALID && RB_READY) begin
        if (exp_rb_q.size() == 0) check("rb_unexpected", 32'(RB_VALID), 32'd0);
        else check("rb_data", 32'(RB_DATA), 32'(exp_rb_q.pop_front()));
      end
      if (DONE) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (ERROR) err_cnt <= err_cnt + 1;
    end
  end

  // driver tasks
  task automatic issue_cmd(input logic [1:0] op, output int acc);
    int g;
    g = 0;
    acc = -1;
    @(posedge SYSCLK); #1;
    CMD_OP = op;
    CMD_VALID = 1'b1;
    while (acc < 0) begin
      @(negedge SYSCLK);
      if (CMD_READY) acc = cyc;
      else begin
        g++;
        if (g > 100) begin
          check("cmd_accept_timeout", 32'(CMD_READY), 32'd1);
          acc = cyc;
        end
      end
    end
    @(posedge SYSCLK); #1;
    CMD_VALID = 1'b0;
    CMD_OP = 2'd0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    int g;
    g = 0;
    @(posedge SYSCLK); #1;
    WR_DATA = b;
    WR_VALID = 1'b1;
    @(negedge SYSCLK);
    while (!WR_READY && g < 100) begin
      @(negedge SYSCLK);
      g++;
    end
    if (!WR_READY) check("wr_ready_timeout", 32'(WR_READY), 32'd1);
    @(posedge SYSCLK); #1;
    WR_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int d0, g;
    d0 = done_cnt;
    g = 0;
    while (done_cnt == d0 && g < 400) begin
      @(negedge SYSCLK); #1;
      g++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic push_readback_expect();
    logic [7:0] b;
    for (int i = 0; i < L; i++) exp_head_q.push_back(model_bits[i]);
    for (int k = 0; k < NB; k++) begin
      b = 8'd0;
      for (int j = 0; j < 8; j++) if (k * 8 + j < L) b[j] = model_bits[k * 8 + j];
      exp_rb_q.push_back(b);
    end
  endtask

  task automatic do_load(input logic [8*NB-1:0] v, input bit poke);
    int acc, ce0, wr0, e0;
    ce0 = ce_cnt; wr0 = wr_cnt; e0 = err_cnt;
    for (int i = 0; i < L; i++) begin
      model_bits[i] = v[i];
      exp_head_q.push_back(v[i]);
    end
    issue_cmd(2'd1, acc);
    if (poke) begin
      CMD_VALID = 1'b1;
      CMD_OP = 2'd3;
      @(negedge SYSCLK);
      check("busy_cmd_ignored", 32'({CMD_READY, BUSY, WR_READY}), 32'b011);
      @(posedge SYSCLK); #1;
      CMD_VALID = 1'b0;
      CMD_OP = 2'd0;
    end
    for (int k = 0; k < NB; k++) wr_byte(v[k*8 +: 8]);
    wait_done();
    check("load_ce_pulses", 32'(ce_cnt - ce0), 32'(L));
    check("load_wr_handshakes", 32'(wr_cnt - wr0), 32'(NB));
    check("load_no_error", 32'(err_cnt - e0), 32'd0);
  endtask

  task automatic do_readback(input int first_stall);
    int acc, ce0, e0, g, stall;
    logic [7:0] held;
    ce0 = ce_cnt; e0 = err_cnt;
    push_readback_expect();
    issue_cmd(2'd2, acc);
    for (int k = 0; k < NB; k++) begin
      g = 0;
      @(negedge SYSCLK);
      while (!RB_VALID && g < 40) begin
        @(negedge SYSCLK);
        g++;
      end
      check("rb_valid_seen", 32'(RB_VALID), 32'd1);
      held = RB_DATA;
      stall = (k == 0) ? first_stall : int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        @(negedge SYSCLK);
        check("rb_hold", 32'({RB_VALID, SHIFT_ENABLE, RB_DATA}), 32'({1'b1, 1'b0, held}));
      end
      @(posedge SYSCLK); #1;
      RB_READY = 1'b1;
      @(posedge SYSCLK); #1;
      RB_READY = 1'b0;
    end
    wait_done();
    check("rb_ce_pulses", 32'(ce_cnt - ce0), 32'(L));
    check("rb_no_error", 32'(err_cnt - e0), 32'd0);
  endtask

  task automatic do_clear();
    int acc, ce0;
    ce0 = ce_cnt;
    for (int i = 0; i < L; i++) begin
      model_bits[i] = 1'b0;
      exp_head_q.push_back(1'b0);
    end
    issue_cmd(2'd3, acc);
    wait_done();
    check("clear_done_latency", 32'(done_cyc - acc), 32'(L + 2));
    check("clear_ce_pulses", 32'(ce_cnt - ce0), 32'(L));
  endtask

  task automatic do_abort(input logic [7:0] b);
    int acc, ce0, d0, e0;
    logic nb[L];
    ce0 = ce_cnt; d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) exp_head_q.push_back(b[i]);
    for (int i = 0; i < L; i++) nb[i] = (i < L - 5) ? model_bits[i + 5] : b[i - (L - 5)];
    model_bits = nb;
    issue_cmd(2'd1, acc);
    wr_byte(b);
    repeat (4) @(posedge SYSCLK);
    #1 ABORT = 1'b1;
    @(posedge SYSCLK); #1;
    ABORT = 1'b0;
    @(negedge SYSCLK);
    check("abort_next_cycle", 32'({ERROR, BUSY, SHIFT_ENABLE, CMD_READY, RB_VALID}), 32'b10010);
    repeat (3) @(negedge SYSCLK);
    #1;
    check("abort_ce_pulses", 32'(ce_cnt - ce0), 32'd5);
    check("abort_error_pulse", 32'(err_cnt - e0), 32'd1);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
  endtask

  task automatic do_reset_in_rb();
    int acc, ce0;
    logic t0, t1;
    ce0 = ce_cnt;
    t0 = model_bits[0];
    t1 = model_bits[1];
    exp_head_q.push_back(t0);
    exp_head_q.push_back(t1);
    for (int i = 0; i < L - 2; i++) model_bits[i] = model_bits[i + 2];
    model_bits[L-2] = t0;
    model_bits[L-1] = t1;
    issue_cmd(2'd2, acc);
    @(posedge SYSCLK);
    @(posedge SYSCLK); #2;
    SYSRST = 1'b0;
    #1;
    check("reset_async_outputs",
          32'({BUSY, SHIFT_ENABLE, CMD_READY, RB_VALID, SHIFT_HEAD, DONE, ERROR}), 32'b0010000);
    check("reset_async_rb_data", 32'(RB_DATA), 32'd0);
    check("reset_ce_pulses", 32'(ce_cnt - ce0), 32'd2);
    repeat (2) @(posedge SYSCLK);
    #1 SYSRST = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    int acc, d0, e0;
    logic [8*NB-1:0] v;
    logic bit_v;
    for (int i = 0; i < L; i++) begin
      bit_v = 1'($urandom_range(0, 1));
      chain_q.push_back(bit_v);
      model_bits[i] = bit_v;
    end
    tail_bit = chain_q[0];

    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK);
    check("reset_outputs",
          32'({CMD_READY, WR_READY, RB_VALID, SHIFT_HEAD, SHIFT_ENABLE, BUSY, DONE, ERROR}),
          32'b10000000);
    check("reset_rb_data", 32'(RB_DATA), 32'd0);
    #1 SYSRST = 1'b1;

    // known bitstream, then readback with a long stall on the first byte
    do_load(16'h03A5, 1'b1);
    do_readback(20);
    do_clear();
    do_readback(0);

    v = 16'($urandom);
    do_load(v, 1'b0);
    do_abort(8'($urandom));
    do_readback(1);

    d0 = done_cnt;
    e0 = err_cnt;
    issue_cmd(2'd0, acc);
    @(negedge SYSCLK);
    check("nop_stays_idle", 32'({BUSY, CMD_READY}), 32'b01);
    repeat (3) @(negedge SYSCLK);
    #1;
    check("nop_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

    do_reset_in_rb();
    v = 16'($urandom);
    do_load(v, 1'b0);
    do_readback(2);

    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(1, 3))
        1: begin
          v = 16'($urandom);
          do_load(v, 1'b0);
        end
        2: do_readback(int'($urandom_range(0, 4)));
        default: do_clear();
      endcase
    end
    do_readback(0);

    repeat (2) @(negedge SYSCLK);
    check("head_queue_drained", 32'(exp_head_q.size()), 32'd0);
    check("rb_queue_drained", 32'(exp_rb_q.size()), 32'd0);
    for (int i = 0; i < L; i++) check("chain_content", 32'(chain_q[i]), 32'(model_bits[i]));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
